// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_sequencer
// Brief    : Highway / farm-road light sequencer driving a shared interval
//            timer, with farm-road demand latch and a timer watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int T_HG      = 8,
    parameter int T_Y       = 3,
    parameter int T_AR      = 1,
    parameter int T_FG      = 5,
    parameter int WD_CYCLES = 64
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       sensor,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [1:0] hw_light,
    output logic [1:0] fr_light,
    output logic       fault
);

    localparam logic [1:0] c_RED = 2'b00;
    localparam logic [1:0] c_YEL = 2'b01;
    localparam logic [1:0] c_GRN = 2'b10;
    localparam int         c_WD_W = $clog2(WD_CYCLES + 1);

    typedef enum logic [3:0] {
        S_HG_ARM   = 4'd0,
        S_HG_WAIT  = 4'd1,
        S_HG_HOLD  = 4'd2,
        S_HY_ARM   = 4'd3,
        S_HY_WAIT  = 4'd4,
        S_AR1_ARM  = 4'd5,
        S_AR1_WAIT = 4'd6,
        S_FG_ARM   = 4'd7,
        S_FG_WAIT  = 4'd8,
        S_FY_ARM   = 4'd9,
        S_FY_WAIT  = 4'd10,
        S_AR2_ARM  = 4'd11,
        S_AR2_WAIT = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_car_pending;
    logic [c_WD_W-1:0]   r_wd;
    logic [3:0]          r_value;
    logic                w_is_arm;
    logic                w_is_wait;
    logic                w_in_farm;
    logic                w_wd_trip;

    function automatic logic [3:0] f_dur(input state_t s);
        case (s)
            S_HY_ARM, S_HY_WAIT, S_FY_ARM, S_FY_WAIT:    f_dur = 4'(T_Y);
            S_AR1_ARM, S_AR1_WAIT, S_AR2_ARM, S_AR2_WAIT: f_dur = 4'(T_AR);
            S_FG_ARM, S_FG_WAIT:                         f_dur = 4'(T_FG);
            default:                                     f_dur = 4'(T_HG);
        endcase
    endfunction

    assign w_wd_trip = (r_wd == c_WD_W'(WD_CYCLES - 1));
    assign w_in_farm = (r_state == S_FG_ARM) || (r_state == S_FG_WAIT) ||
                       (r_state == S_FY_ARM) || (r_state == S_FY_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_is_arm    = 1'b0;
        w_is_wait   = 1'b0;
        hw_light    = c_RED;
        fr_light    = c_RED;
        fault       = 1'b0;
        case (r_state)
            S_HG_ARM: begin
                w_is_arm    = 1'b1;
                hw_light    = c_GRN;
                w_state_nxt = S_HG_WAIT;
            end
            S_HG_WAIT: begin
                w_is_wait = 1'b1;
                hw_light  = c_GRN;
                if (expired)
                    w_state_nxt = r_car_pending ? S_HY_ARM : S_HG_HOLD;
                else if (w_wd_trip)
                    w_state_nxt = S_FAULT;
            end
            S_HG_HOLD: begin
                hw_light = c_GRN;
                if (r_car_pending)
                    w_state_nxt = S_HY_ARM;
            end
            S_HY_ARM: begin
                w_is_arm    = 1'b1;
                hw_light    = c_YEL;
                w_state_nxt = S_HY_WAIT;
            end
            S_HY_WAIT: begin
                w_is_wait = 1'b1;
                hw_light  = c_YEL;
                if (expired)        w_state_nxt = S_AR1_ARM;
                else if (w_wd_trip) w_state_nxt = S_FAULT;
            end
            S_AR1_ARM: begin
                w_is_arm    = 1'b1;
                w_state_nxt = S_AR1_WAIT;
            end
            S_AR1_WAIT: begin
                w_is_wait = 1'b1;
                if (expired)        w_state_nxt = S_FG_ARM;
                else if (w_wd_trip) w_state_nxt = S_FAULT;
            end
            S_FG_ARM: begin
                w_is_arm    = 1'b1;
                fr_light    = c_GRN;
                w_state_nxt = S_FG_WAIT;
            end
            S_FG_WAIT: begin
                w_is_wait = 1'b1;
                fr_light  = c_GRN;
                if (expired)        w_state_nxt = S_FY_ARM;
                else if (w_wd_trip) w_state_nxt = S_FAULT;
            end
            S_FY_ARM: begin
                w_is_arm    = 1'b1;
                fr_light    = c_YEL;
                w_state_nxt = S_FY_WAIT;
            end
            S_FY_WAIT: begin
                w_is_wait = 1'b1;
                fr_light  = c_YEL;
                if (expired)        w_state_nxt = S_AR2_ARM;
                else if (w_wd_trip) w_state_nxt = S_FAULT;
            end
            S_AR2_ARM: begin
                w_is_arm    = 1'b1;
                w_state_nxt = S_AR2_WAIT;
            end
            S_AR2_WAIT: begin
                w_is_wait = 1'b1;
                if (expired)        w_state_nxt = S_HG_ARM;
                else if (w_wd_trip) w_state_nxt = S_FAULT;
            end
            S_FAULT: begin
                hw_light = c_YEL;
                fr_light = c_YEL;
                fault    = 1'b1;
            end
            default: w_state_nxt = S_FAULT;
        endcase
    end

    // The pulse is masked while reset is held so the ARM cycle counts only
    // once reset has been released.
    assign start_timer = w_is_arm & ~reset;
    assign value       = r_value;

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state       <= S_HG_ARM;
            r_value       <= 4'(T_HG);
            r_car_pending <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_value <= f_dur(w_state_nxt);
            // Clearing on FG entry takes priority over a same-cycle sensor hit.
            if (w_state_nxt == S_FG_ARM)
                r_car_pending <= 1'b0;
            else if (sensor && !w_in_farm)
                r_car_pending <= 1'b1;
            if (w_is_wait)
                r_wd <= r_wd + c_WD_W'(1);
            else
                r_wd <= '0;
        end
    end

endmodule
`default_nettype wire
